// File: rtl/parking_pool_ctrl.sv
// Two-pool (university / general) parking occupancy controller with an hourly
// capacity hand-over schedule, grant/deny entry handshake and per-pool drain-lock.
module parking_pool_ctrl #(
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned UNI_CAP       = 500,
  parameter int unsigned MISC_CAP      = 200,
  parameter int unsigned NIGHT_UNI_CAP = 200,
  parameter int unsigned STEP          = 50,
  parameter int unsigned SHIFT_START   = 13,
  parameter int unsigned SHIFT_END     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic [5:0]       hour,
  input  logic             ent_valid,
  input  logic             ent_uni,
  input  logic             ex_valid,
  input  logic             ex_uni,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] uni_parked,
  output logic [CNT_W-1:0] misc_parked,
  output logic [CNT_W-1:0] uni_cap,
  output logic [CNT_W-1:0] misc_cap,
  output logic [CNT_W-1:0] uni_vacant,
  output logic [CNT_W-1:0] misc_vacant,
  output logic             uni_has_space,
  output logic             misc_has_space,
  output logic             ent_grant,
  output logic             ent_deny,
  output logic             ex_err,
  output logic             uni_over,
  output logic             misc_over,
  output logic             hour_err,
  output logic             fault
);

  localparam int unsigned TOTAL    = UNI_CAP + MISC_CAP;
  localparam int unsigned AW       = CNT_W + 4;
  localparam int unsigned HOUR_MAX = 23;

  // Reject parameter sets whose capacities cannot be represented or ordered.
  if (((TOTAL >> CNT_W) != 0) || (NIGHT_UNI_CAP > UNI_CAP)) begin : g_bad_params
    $error("parking_pool_ctrl: TOTAL must fit CNT_W and NIGHT_UNI_CAP <= UNI_CAP");
  end

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_OVER   = 1'b1
  } pool_st_e;

  pool_st_e uni_st_q, uni_st_d;
  pool_st_e misc_st_q, misc_st_d;

  logic [CNT_W-1:0] uni_parked_q, uni_parked_d;
  logic [CNT_W-1:0] misc_parked_q, misc_parked_d;
  logic [CNT_W-1:0] uni_cap_q, uni_cap_d;
  logic [CNT_W-1:0] misc_cap_q, misc_cap_d;
  logic [CNT_W-1:0] uni_vacant_q, uni_vacant_d;
  logic [CNT_W-1:0] misc_vacant_q, misc_vacant_d;
  logic             uni_has_space_q, uni_has_space_d;
  logic             misc_has_space_q, misc_has_space_d;
  logic             ent_grant_q, ent_grant_d;
  logic             ent_deny_q, ent_deny_d;
  logic             ex_err_q, ex_err_d;
  logic             hour_err_q, hour_err_d;
  logic             fault_q, fault_d;

  logic             hour_bad;
  logic [AW-1:0]    hour_w;
  logic [AW-1:0]    steps_w;
  logic [AW-1:0]    shrink_w;
  logic [AW-1:0]    sched_w;
  logic             uni_grant, misc_grant;
  logic             uni_exit, misc_exit;
  logic             uni_dec, misc_dec;
  logic             fault_cond;

  assign hour_bad = (hour > 6'(HOUR_MAX));

  // University capacity implied by the hour, clamped at the night floor.
  always_comb begin
    hour_w   = AW'(hour);
    steps_w  = '0;
    shrink_w = '0;
    sched_w  = AW'(UNI_CAP);
    if (hour_w >= AW'(SHIFT_END)) begin
      sched_w = AW'(NIGHT_UNI_CAP);
    end else if (hour_w >= AW'(SHIFT_START)) begin
      steps_w  = hour_w - AW'(SHIFT_START) + AW'(1);
      shrink_w = steps_w * AW'(STEP);
      if (shrink_w >= AW'(UNI_CAP - NIGHT_UNI_CAP)) begin
        sched_w = AW'(NIGHT_UNI_CAP);
      end else begin
        sched_w = AW'(UNI_CAP) - shrink_w;
      end
    end
  end

  // Occupancy, capacity and handshake next-state; everything holds when disabled.
  always_comb begin
    uni_parked_d  = uni_parked_q;
    misc_parked_d = misc_parked_q;
    uni_cap_d     = uni_cap_q;
    misc_cap_d    = misc_cap_q;
    hour_err_d    = hour_err_q;
    ent_grant_d   = 1'b0;
    ent_deny_d    = 1'b0;
    ex_err_d      = 1'b0;
    uni_grant     = 1'b0;
    misc_grant    = 1'b0;
    uni_exit      = 1'b0;
    misc_exit     = 1'b0;
    uni_dec       = 1'b0;
    misc_dec      = 1'b0;
    if (enabled) begin
      hour_err_d = hour_bad;
      if (!hour_bad) begin
        uni_cap_d  = CNT_W'(sched_w);
        misc_cap_d = CNT_W'(TOTAL) - CNT_W'(sched_w);
      end
      if (ent_valid) begin
        if (ent_uni) begin
          uni_grant = (uni_st_q == ST_NORMAL) && (uni_parked_q < uni_cap_q);
        end else begin
          misc_grant = (misc_st_q == ST_NORMAL) && (misc_parked_q < misc_cap_q);
        end
        ent_grant_d = uni_grant | misc_grant;
        ent_deny_d  = ~(uni_grant | misc_grant);
      end
      // A same-pool grant makes the coincident exit legal even from an empty pool.
      uni_exit      = ex_valid & ex_uni;
      misc_exit     = ex_valid & ~ex_uni;
      uni_dec       = uni_exit & ((uni_parked_q != '0) | uni_grant);
      misc_dec      = misc_exit & ((misc_parked_q != '0) | misc_grant);
      ex_err_d      = (uni_exit & ~uni_dec) | (misc_exit & ~misc_dec);
      uni_parked_d  = uni_parked_q + CNT_W'(uni_grant) - CNT_W'(uni_dec);
      misc_parked_d = misc_parked_q + CNT_W'(misc_grant) - CNT_W'(misc_dec);
    end
  end

  // Vacancy is derived from next-state values so it agrees with the counts it is shown with.
  always_comb begin
    uni_vacant_d     = (uni_parked_d >= uni_cap_d) ? '0 : (uni_cap_d - uni_parked_d);
    misc_vacant_d    = (misc_parked_d >= misc_cap_d) ? '0 : (misc_cap_d - misc_parked_d);
    uni_has_space_d  = (uni_vacant_d != '0);
    misc_has_space_d = (misc_vacant_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uni_st_q  <= ST_NORMAL;
      misc_st_q <= ST_NORMAL;
    end else begin
      uni_st_q  <= uni_st_d;
      misc_st_q <= misc_st_d;
    end
  end

  // Drain-lock FSMs: a pool pushed over capacity stays locked until it drains to cap.
  always_comb begin
    uni_st_d  = uni_st_q;
    misc_st_d = misc_st_q;
    case (uni_st_q)
      ST_NORMAL: if (uni_parked_d > uni_cap_d)  uni_st_d = ST_OVER;
      ST_OVER:   if (uni_parked_d <= uni_cap_d) uni_st_d = ST_NORMAL;
      default:   uni_st_d = ST_NORMAL;
    endcase
    case (misc_st_q)
      ST_NORMAL: if (misc_parked_d > misc_cap_d)  misc_st_d = ST_OVER;
      ST_OVER:   if (misc_parked_d <= misc_cap_d) misc_st_d = ST_NORMAL;
      default:   misc_st_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    uni_over  = (uni_st_q == ST_OVER);
    misc_over = (misc_st_q == ST_OVER);
  end

  // Sticky fault: a live condition always wins over clear_fault.
  always_comb begin
    fault_cond = (uni_st_d == ST_OVER) | (misc_st_d == ST_OVER) | (enabled & hour_bad);
    fault_d    = fault_q;
    if (enabled) begin
      fault_d = fault_cond | (fault_q & ~clear_fault);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uni_parked_q     <= '0;
      misc_parked_q    <= '0;
      uni_cap_q        <= CNT_W'(UNI_CAP);
      misc_cap_q       <= CNT_W'(MISC_CAP);
      uni_vacant_q     <= CNT_W'(UNI_CAP);
      misc_vacant_q    <= CNT_W'(MISC_CAP);
      uni_has_space_q  <= 1'b1;
      misc_has_space_q <= 1'b1;
      ent_grant_q      <= 1'b0;
      ent_deny_q       <= 1'b0;
      ex_err_q         <= 1'b0;
      hour_err_q       <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      uni_parked_q     <= uni_parked_d;
      misc_parked_q    <= misc_parked_d;
      uni_cap_q        <= uni_cap_d;
      misc_cap_q       <= misc_cap_d;
      uni_vacant_q     <= uni_vacant_d;
      misc_vacant_q    <= misc_vacant_d;
      uni_has_space_q  <= uni_has_space_d;
      misc_has_space_q <= misc_has_space_d;
      ent_grant_q      <= ent_grant_d;
      ent_deny_q       <= ent_deny_d;
      ex_err_q         <= ex_err_d;
      hour_err_q       <= hour_err_d;
      fault_q          <= fault_d;
    end
  end

  assign uni_parked     = uni_parked_q;
  assign misc_parked    = misc_parked_q;
  assign uni_cap        = uni_cap_q;
  assign misc_cap       = misc_cap_q;
  assign uni_vacant     = uni_vacant_q;
  assign misc_vacant    = misc_vacant_q;
  assign uni_has_space  = uni_has_space_q;
  assign misc_has_space = misc_has_space_q;
  assign ent_grant      = ent_grant_q;
  assign ent_deny       = ent_deny_q;
  assign ex_err         = ex_err_q;
  assign hour_err       = hour_err_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_parking_pool_ctrl.sv
// Directed bench for parking_pool_ctrl: a reference model pushes expected outputs
// to a scoreboard queue as each stimulus cycle is driven; results are popped after the edge.
module tb_parking_pool_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enabled;
  logic [5:0] hour;
  logic       ent_valid, ent_uni, ex_valid, ex_uni, clear_fault;
  logic [9:0] uni_parked, misc_parked, uni_cap, misc_cap, uni_vacant, misc_vacant;
  logic       uni_has_space, misc_has_space, ent_grant, ent_deny, ex_err;
  logic       uni_over, misc_over, hour_err, fault;

  parking_pool_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .hour(hour),
    .ent_valid(ent_valid), .ent_uni(ent_uni), .ex_valid(ex_valid), .ex_uni(ex_uni),
    .clear_fault(clear_fault),
    .uni_parked(uni_parked), .misc_parked(misc_parked),
    .uni_cap(uni_cap), .misc_cap(misc_cap),
    .uni_vacant(uni_vacant), .misc_vacant(misc_vacant),
    .uni_has_space(uni_has_space), .misc_has_space(misc_has_space),
    .ent_grant(ent_grant), .ent_deny(ent_deny), .ex_err(ex_err),
    .uni_over(uni_over), .misc_over(misc_over), .hour_err(hour_err), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int up, mp, ucap, mcap, uvac, mvac;
    bit ush, msh, g, d, xe, uo, mo, he, f;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   grants = 0;

  int m_up, m_mp, m_ucap, m_mcap;
  bit m_g, m_d, m_xe, m_uo, m_mo, m_he, m_f;

  function automatic int sched(input int hr);
    int c;
    if (hr < 13) return 500;
    if (hr >= 16) return 200;
    c = 500 - (hr - 12) * 50;
    return (c < 200) ? 200 : c;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.up = m_up; e.mp = m_mp; e.ucap = m_ucap; e.mcap = m_mcap;
    e.uvac = (m_ucap > m_up) ? m_ucap - m_up : 0;
    e.mvac = (m_mcap > m_mp) ? m_mcap - m_mp : 0;
    e.ush = (e.uvac != 0); e.msh = (e.mvac != 0);
    e.g = m_g; e.d = m_d; e.xe = m_xe; e.uo = m_uo; e.mo = m_mo; e.he = m_he; e.f = m_f;
    return e;
  endfunction

  task automatic model_reset();
    m_up = 0; m_mp = 0; m_ucap = 500; m_mcap = 200;
    m_g = 0; m_d = 0; m_xe = 0; m_uo = 0; m_mo = 0; m_he = 0; m_f = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("uni_parked", int'(uni_parked), e.up);
    chk("misc_parked", int'(misc_parked), e.mp);
    chk("uni_cap", int'(uni_cap), e.ucap);
    chk("misc_cap", int'(misc_cap), e.mcap);
    chk("uni_vacant", int'(uni_vacant), e.uvac);
    chk("misc_vacant", int'(misc_vacant), e.mvac);
    chk("uni_has_space", int'(uni_has_space), int'(e.ush));
    chk("misc_has_space", int'(misc_has_space), int'(e.msh));
    chk("ent_grant", int'(ent_grant), int'(e.g));
    chk("ent_deny", int'(ent_deny), int'(e.d));
    chk("ex_err", int'(ex_err), int'(e.xe));
    chk("uni_over", int'(uni_over), int'(e.uo));
    chk("misc_over", int'(misc_over), int'(e.mo));
    chk("hour_err", int'(hour_err), int'(e.he));
    chk("fault", int'(fault), int'(e.f));
  endtask

  task automatic check_out();
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      compare(sb_q.pop_front());
    end
  endtask

  // One clock of stimulus: update the model, queue its prediction, sample after the edge.
  task automatic step(input bit en, input int hr, input bit ev, input bit eu,
                      input bit xv, input bit xu, input bit cf);
    bit ug, mg, udec, mdec;
    int ncap;
    enabled = en; hour = 6'(hr); ent_valid = ev; ent_uni = eu;
    ex_valid = xv; ex_uni = xu; clear_fault = cf;
    m_g = 0; m_d = 0; m_xe = 0;
    if (en) begin
      m_he = (hr > 23);
      ncap = m_he ? m_ucap : sched(hr);
      ug = ev && eu && !m_uo && (m_up < m_ucap);
      mg = ev && !eu && !m_mo && (m_mp < m_mcap);
      m_g = ug || mg;
      m_d = ev && !m_g;
      udec = xv && xu && ((m_up > 0) || ug);
      mdec = xv && !xu && ((m_mp > 0) || mg);
      m_xe = (xv && xu && !udec) || (xv && !xu && !mdec);
      m_up = m_up + int'(ug) - int'(udec);
      m_mp = m_mp + int'(mg) - int'(mdec);
      m_ucap = ncap;
      m_mcap = 700 - ncap;
      m_uo = (m_up > m_ucap);
      m_mo = (m_mp > m_mcap);
      m_f = m_uo || m_mo || m_he || (m_f && !cf);
    end
    sb_q.push_back(snap());
    @(posedge clk);
    #1;
    if (ent_grant === 1'b1) grants++;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0; enabled = 1'b0; hour = 6'd9;
    ent_valid = 1'b0; ent_uni = 1'b0; ex_valid = 1'b0; ex_uni = 1'b0; clear_fault = 1'b0;
    model_reset();
    #12;
    compare(snap());
    chk("reset_uni_vacant", int'(uni_vacant), 500);
    rst_n = 1'b1;
    #1;

    // Three university entries then one exit at hour 9.
    for (int i = 0; i < 3; i++) step(1, 9, 1, 1, 0, 0, 0);
    chk("three_grants", grants, 3);
    step(1, 9, 0, 0, 1, 1, 0);
    chk("uni_parked_2", int'(uni_parked), 2);
    chk("uni_vacant_498", int'(uni_vacant), 498);
    chk("misc_vacant_200", int'(misc_vacant), 200);

    // Fill the general pool, overflow attempt, then coincident exit + entry.
    for (int i = 0; i < 200; i++) step(1, 9, 1, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0);
    chk("misc_full_deny", int'(ent_deny), 1);
    chk("misc_full_space", int'(misc_has_space), 0);
    step(1, 9, 1, 0, 1, 0, 0);
    chk("misc_199", int'(misc_parked), 199);

    // Bring university to 420, then walk the shift window.
    for (int i = 0; i < 418; i++) step(1, 12, 1, 1, 0, 0, 0);
    step(1, 12, 0, 0, 0, 0, 0);
    chk("cap_h12", int'(uni_cap), 500);
    step(1, 13, 0, 0, 0, 0, 0);
    chk("cap_h13", int'(misc_cap), 250);
    step(1, 14, 0, 0, 0, 0, 0);
    chk("cap_h14", int'(uni_cap), 400);
    chk("over_h14", int'(uni_over), 1);
    step(1, 14, 1, 1, 0, 0, 0);
    chk("over_deny", int'(ent_deny), 1);
    for (int i = 0; i < 20; i++) step(1, 14, 0, 0, 1, 1, 0);
    chk("over_cleared", int'(uni_over), 0);
    step(1, 14, 0, 0, 1, 1, 0);
    step(1, 14, 1, 1, 0, 0, 0);
    chk("regrant", int'(ent_grant), 1);

    // Drain university to the night capacity, then night hours and bad hour.
    for (int i = 0; i < 200; i++) step(1, 14, 0, 0, 1, 1, 0);
    step(1, 16, 0, 0, 0, 0, 0);
    chk("night_misc_cap", int'(misc_cap), 500);
    step(1, 30, 0, 0, 0, 0, 0);
    chk("hour_err", int'(hour_err), 1);
    chk("hold_cap", int'(uni_cap), 200);
    step(1, 17, 0, 0, 0, 0, 1);
    chk("fault_cleared", int'(fault), 0);

    // Empty the general pool and exit once more; then disabled cycles.
    for (int i = 0; i < 199; i++) step(1, 17, 0, 0, 1, 0, 0);
    step(1, 17, 0, 0, 1, 0, 0);
    chk("empty_ex_err", int'(ex_err), 1);
    step(0, 17, 1, 1, 0, 0, 0);
    step(0, 17, 0, 0, 1, 1, 0);
    step(0, 30, 1, 0, 1, 0, 0);

    // Drain university to 57, then hit reset in the middle of an entry burst.
    for (int i = 0; i < 143; i++) step(1, 17, 0, 0, 1, 1, 0);
    chk("uni_57", int'(uni_parked), 57);
    enabled = 1'b1; hour = 6'd17; ent_valid = 1'b1; ent_uni = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare(snap());
    ent_valid = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 9, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
